// File: rtl/run_ctrl.sv
// Run-control and performance counters for the accumulator core: sequences
// IDLE -> RUN -> DONE, gates retirement with run_en and keeps saturating counters.
module run_ctrl #(
    parameter int CW   = 16,
    parameter int NEV  = 4,
    parameter int WDOG = 0
) (
    input  logic                CLK,
    input  logic                start,
    input  logic                Halt,
    input  logic                stall,
    input  logic [NEV-1:0]      ev,
    output logic                run_en,
    output logic                program_done,
    output logic                timeout,
    output logic [CW-1:0]       cycle_ct,
    output logic [CW-1:0]       instr_ct,
    output logic [CW-1:0]       stall_ct,
    output logic [NEV*CW-1:0]   ev_ct,
    output logic [3+NEV-1:0]    ovf
);

    localparam int              NC       = 3 + NEV;
    localparam logic [CW-1:0]   CNT_MAX  = '1;
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam int unsigned     WDOG_M1  = (WDOG == 0) ? 0 : WDOG - 1;
    localparam logic [CW-1:0]   WDOG_LAST = CW'(WDOG_M1);
    localparam bit              WDOG_EN  = (WDOG != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_timeout;
    logic [NC-1:0][CW-1:0]  r_cnt;
    logic [NC-1:0]          r_ovf;
    logic [NC-1:0]          w_inc;
    logic                   w_in_run;
    logic                   w_run_en;
    logic                   w_wdog_fire;
    logic                   w_set_timeout;

    assign w_in_run    = (r_state == S_RUN);
    assign w_run_en    = w_in_run && !stall;
    // Watchdog compares against the pre-increment cycle count, so it ends the run after exactly WDOG cycles.
    assign w_wdog_fire = WDOG_EN && w_in_run && (r_cnt[0] == WDOG_LAST);

    always_ff @(posedge CLK or posedge start) begin
        if (start) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_set_timeout = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_wdog_fire) begin
                    w_state_nxt   = S_DONE;
                    w_set_timeout = 1'b1;
                end else if (w_run_en && Halt) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge start) begin
        if (start) begin
            r_timeout <= 1'b0;
        end else if (w_set_timeout) begin
            r_timeout <= 1'b1;
        end
    end

    // Index map: 0 cycle, 1 instr, 2 stall, 3+i event channel i.
    always_comb begin
        w_inc    = '0;
        w_inc[0] = w_in_run;
        w_inc[1] = w_run_en;
        w_inc[2] = w_in_run && stall;
        for (int i = 0; i < NEV; i++) begin
            w_inc[3+i] = w_run_en && ev[i];
        end
    end

    always_ff @(posedge CLK or posedge start) begin
        if (start) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (w_inc[k]) begin
                    if (r_cnt[k] == CNT_MAX) begin
                        r_ovf[k] <= 1'b1;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + CNT_ONE;
                    end
                end
            end
        end
    end

    assign run_en       = w_run_en;
    assign program_done = (r_state == S_DONE);
    assign timeout      = r_timeout;
    assign cycle_ct     = r_cnt[0];
    assign instr_ct     = r_cnt[1];
    assign stall_ct     = r_cnt[2];
    assign ovf          = r_ovf;

    for (genvar g = 0; g < NEV; g++) begin : g_ev_out
        assign ev_ct[g*CW +: CW] = r_cnt[3+g];
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: three instances (default, CW=4, WDOG=8) share stimulus.
module tb_run_ctrl;

    logic        CLK = 1'b0;
    logic        start = 1'b0;
    logic        Halt = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  ev = 4'd0;

    int total = 0;
    int bad = 0;

    logic        a_run_en, a_done, a_to;
    logic [15:0] a_cyc, a_ins, a_stl;
    logic [63:0] a_ev;
    logic [6:0]  a_ovf;

    logic        s_run_en, s_done, s_to;
    logic [3:0]  s_cyc, s_ins, s_stl;
    logic [15:0] s_ev;
    logic [6:0]  s_ovf;

    logic        w_run_en, w_done, w_to;
    logic [15:0] w_cyc, w_ins, w_stl;
    logic [63:0] w_ev;
    logic [6:0]  w_ovf;

    always #5 CLK = ~CLK;

    run_ctrl #(.CW(16), .NEV(4), .WDOG(0)) u_a (
        .CLK(CLK), .start(start), .Halt(Halt), .stall(stall), .ev(ev),
        .run_en(a_run_en), .program_done(a_done), .timeout(a_to),
        .cycle_ct(a_cyc), .instr_ct(a_ins), .stall_ct(a_stl), .ev_ct(a_ev), .ovf(a_ovf)
    );

    run_ctrl #(.CW(4), .NEV(4), .WDOG(0)) u_s (
        .CLK(CLK), .start(start), .Halt(Halt), .stall(stall), .ev(ev),
        .run_en(s_run_en), .program_done(s_done), .timeout(s_to),
        .cycle_ct(s_cyc), .instr_ct(s_ins), .stall_ct(s_stl), .ev_ct(s_ev), .ovf(s_ovf)
    );

    run_ctrl #(.CW(16), .NEV(4), .WDOG(8)) u_w (
        .CLK(CLK), .start(start), .Halt(Halt), .stall(stall), .ev(ev),
        .run_en(w_run_en), .program_done(w_done), .timeout(w_to),
        .cycle_ct(w_cyc), .instr_ct(w_ins), .stall_ct(w_stl), .ev_ct(w_ev), .ovf(w_ovf)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench 1 time unit after the IDLE->RUN edge, i.e. at the start of RUN cycle 1.
    task automatic begin_run();
        start = 1'b1;
        Halt  = 1'b0;
        stall = 1'b0;
        ev    = 4'd0;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2 start = 1'b1;
        #1;
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", a_done); end
        total++; if (a_to !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b want=0", a_to); end
        total++; if (a_cyc !== 16'd0 || a_ins !== 16'd0 || a_stl !== 16'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", a_cyc, a_ins, a_stl); end
        total++; if (a_ev !== 64'd0 || a_ovf !== 7'd0) begin bad++; $display("FAIL reset_ev_ovf got=%0h/%0h want=0/0", a_ev, a_ovf); end
        tick();
        tick();
        total++; if (a_run_en !== 1'b0 || a_cyc !== 16'd0) begin bad++; $display("FAIL reset_hold got run_en=%0b cyc=%0d want 0/0", a_run_en, a_cyc); end
    endtask

    task automatic test_basic_halt();
        begin_run();
        total++; if (a_run_en !== 1'b1) begin bad++; $display("FAIL basic_first_run_en got=%0b want=1", a_run_en); end
        for (int i = 1; i <= 10; i++) begin
            Halt = (i == 10);
            #1;
            if (i == 10) begin
                total++; if (a_done !== 1'b0 || a_run_en !== 1'b1) begin bad++; $display("FAIL basic_pre_halt got done=%0b run_en=%0b want 0/1", a_done, a_run_en); end
            end
            tick();
        end
        Halt = 1'b0;
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0b want=1", a_done); end
        total++; if (a_cyc !== 16'd10) begin bad++; $display("FAIL basic_cycle got=%0d want=10", a_cyc); end
        total++; if (a_ins !== 16'd10) begin bad++; $display("FAIL basic_instr got=%0d want=10", a_ins); end
        total++; if (a_stl !== 16'd0 || a_to !== 1'b0) begin bad++; $display("FAIL basic_stall_to got=%0d/%0b want=0/0", a_stl, a_to); end
        total++; if (a_run_en !== 1'b0) begin bad++; $display("FAIL basic_run_en_after got=%0b want=0", a_run_en); end
        tick();
        tick();
        total++; if (a_cyc !== 16'd10 || a_done !== 1'b1) begin bad++; $display("FAIL basic_freeze got cyc=%0d done=%0b want 10/1", a_cyc, a_done); end
    endtask

    task automatic test_stall_events();
        begin_run();
        for (int i = 1; i <= 20; i++) begin
            stall = (i == 3 || i == 4 || i == 8 || i == 12 || i == 17);
            ev[0] = 1'b1;
            ev[1] = stall;
            ev[2] = (i == 20);
            ev[3] = 1'b0;
            Halt  = (i == 20);
            tick();
        end
        Halt = 1'b0; stall = 1'b0; ev = 4'd0;
        total++; if (a_cyc !== 16'd20) begin bad++; $display("FAIL stev_cycle got=%0d want=20", a_cyc); end
        total++; if (a_ins !== 16'd15) begin bad++; $display("FAIL stev_instr got=%0d want=15", a_ins); end
        total++; if (a_stl !== 16'd5) begin bad++; $display("FAIL stev_stall got=%0d want=5", a_stl); end
        total++; if (a_ev[15:0] !== 16'd15) begin bad++; $display("FAIL stev_ev0 got=%0d want=15", a_ev[15:0]); end
        total++; if (a_ev[31:16] !== 16'd0) begin bad++; $display("FAIL stev_ev1_stalled got=%0d want=0", a_ev[31:16]); end
        total++; if (a_ev[47:32] !== 16'd1) begin bad++; $display("FAIL stev_ev2_halt got=%0d want=1", a_ev[47:32]); end
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL stev_done got=%0b want=1", a_done); end
    endtask

    task automatic test_halt_under_stall();
        begin_run();
        tick();
        tick();
        for (int j = 0; j < 3; j++) begin
            Halt = 1'b1;
            stall = 1'b1;
            #1;
            total++; if (a_run_en !== 1'b0) begin bad++; $display("FAIL hus_run_en got=%0b want=0", a_run_en); end
            tick();
            total++; if (a_done !== 1'b0) begin bad++; $display("FAIL hus_early_done got=%0b want=0", a_done); end
        end
        stall = 1'b0;
        #1;
        total++; if (a_run_en !== 1'b1) begin bad++; $display("FAIL hus_release_run_en got=%0b want=1", a_run_en); end
        tick();
        Halt = 1'b0;
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL hus_done got=%0b want=1", a_done); end
        total++; if (a_cyc !== 16'd6 || a_ins !== 16'd3 || a_stl !== 16'd3) begin bad++; $display("FAIL hus_counts got=%0d/%0d/%0d want=6/3/3", a_cyc, a_ins, a_stl); end
    endtask

    task automatic test_saturation();
        begin_run();
        ev = 4'b1000;
        for (int i = 1; i <= 15; i++) tick();
        total++; if (s_cyc !== 4'd15 || s_ovf !== 7'd0) begin bad++; $display("FAIL sat_at_max got cyc=%0d ovf=%0h want 15/0", s_cyc, s_ovf); end
        for (int i = 16; i <= 20; i++) tick();
        total++; if (s_cyc !== 4'd15 || s_ins !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d/%0d want=15/15", s_cyc, s_ins); end
        total++; if (s_ovf !== 7'b1000011) begin bad++; $display("FAIL sat_ovf got=%b want=1000011", s_ovf); end
        total++; if (s_ev[15:12] !== 4'd15 || s_stl !== 4'd0) begin bad++; $display("FAIL sat_ev3_stall got=%0d/%0d want=15/0", s_ev[15:12], s_stl); end
        start = 1'b1;
        #1;
        total++; if (s_cyc !== 4'd0 || s_ins !== 4'd0 || s_ovf !== 7'd0 || s_ev !== 16'd0) begin bad++; $display("FAIL sat_clear got cyc=%0d ins=%0d ovf=%0h ev=%0h want all 0", s_cyc, s_ins, s_ovf, s_ev); end
        start = 1'b0;
        ev = 4'd0;
    endtask

    task automatic test_watchdog();
        begin_run();
        for (int i = 1; i <= 7; i++) tick();
        total++; if (w_done !== 1'b0 || w_cyc !== 16'd7) begin bad++; $display("FAIL wd_before got done=%0b cyc=%0d want 0/7", w_done, w_cyc); end
        tick();
        total++; if (w_done !== 1'b1 || w_to !== 1'b1) begin bad++; $display("FAIL wd_fire got done=%0b to=%0b want 1/1", w_done, w_to); end
        total++; if (w_cyc !== 16'd8 || w_ins !== 16'd8) begin bad++; $display("FAIL wd_counts got=%0d/%0d want=8/8", w_cyc, w_ins); end
        for (int i = 0; i < 4; i++) tick();
        total++; if (w_cyc !== 16'd8 || w_ins !== 16'd8 || w_run_en !== 1'b0) begin bad++; $display("FAIL wd_hold got cyc=%0d ins=%0d run_en=%0b want 8/8/0", w_cyc, w_ins, w_run_en); end
    endtask

    task automatic test_wdog_and_halt();
        begin_run();
        for (int i = 1; i <= 8; i++) begin
            Halt  = (i == 8);
            ev[1] = (i == 8);
            tick();
        end
        Halt = 1'b0; ev = 4'd0;
        total++; if (w_to !== 1'b1 || w_done !== 1'b1) begin bad++; $display("FAIL wdh_flags got to=%0b done=%0b want 1/1", w_to, w_done); end
        total++; if (w_ins !== 16'd8 || w_ev[31:16] !== 16'd1) begin bad++; $display("FAIL wdh_halt_counted got ins=%0d ev1=%0d want 8/1", w_ins, w_ev[31:16]); end
        total++; if (a_to !== 1'b0 || a_done !== 1'b1) begin bad++; $display("FAIL wdh_nowd got to=%0b done=%0b want 0/1", a_to, a_done); end
    endtask

    task automatic test_midrun_reset();
        begin_run();
        for (int i = 1; i <= 5; i++) tick();
        total++; if (a_cyc !== 16'd5) begin bad++; $display("FAIL mid_pre got=%0d want=5", a_cyc); end
        #2 start = 1'b1;
        #1;
        total++; if (a_cyc !== 16'd0 || a_ins !== 16'd0 || a_done !== 1'b0 || a_run_en !== 1'b0 || a_ovf !== 7'd0) begin bad++; $display("FAIL mid_async_clear got cyc=%0d ins=%0d done=%0b run_en=%0b ovf=%0h want all 0", a_cyc, a_ins, a_done, a_run_en, a_ovf); end
        tick();
        total++; if (a_run_en !== 1'b0) begin bad++; $display("FAIL mid_idle_hold got=%0b want=0", a_run_en); end
        start = 1'b0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            Halt = (i == 3);
            tick();
        end
        Halt = 1'b0;
        total++; if (a_cyc !== 16'd3 || a_ins !== 16'd3 || a_done !== 1'b1 || a_to !== 1'b0) begin bad++; $display("FAIL mid_restart got cyc=%0d ins=%0d done=%0b to=%0b want 3/3/1/0", a_cyc, a_ins, a_done, a_to); end
    endtask

    initial begin
        test_reset();
        test_basic_halt();
        test_stall_events();
        test_halt_under_stall();
        test_saturation();
        test_watchdog();
        test_wdog_and_halt();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised run-control and performance-counter unit for the accumulator processor. It sequences the core from reset to completion and gates forward progress with `run_en` to the PC, register file, accumulator and data memory write path. It generates `program_done` and replaces the single ad-hoc cycle counter with width-configurable, saturating counters for cycles, retired instructions, stall cycles and NEV event channels, plus an optional watchdog.

## Interface
Parameters:
- CW, 16: width of every counter.
- NEV, 4: number of event-counter channels, 1..8.
- WDOG, 0: watchdog limit in cycles. 0 disables the watchdog. Otherwise it must be ≤ 2^CW-1.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- start  in  1  asynchronous active-high reset / init; run begins after release.
- Halt  in  1  current instruction is HALT (from Ctrl).
- stall  in  1  current instruction cannot retire this cycle (memory wait).
- ev  in  NEV  per-channel event qualifiers for the current instruction (e.g. branch taken, jump, ram_write).
- run_en  out  1  current instruction retires this cycle; PC and state elements advance only when high.
- program_done  out  1  run finished (normal halt or watchdog).
- timeout  out  1  run ended by watchdog.
- cycle_ct  out  CW  cycles spent in RUN.
- instr_ct  out  CW  retired instructions.
- stall_ct  out  CW  RUN cycles with stall high.
- ev_ct  out  NEV*CW  channel i occupies bits [i*CW +: CW].
- ovf  out  3+NEV  sticky saturation flags: bit0 cycle, bit1 instr, bit2 stall, bit3+i event i.

## Operation
- FSM states are IDLE, RUN and DONE. The reset value is IDLE.
- While `start` is high, the FSM stays in IDLE. All counters, `ovf`, `timeout` and `program_done` are 0.
- IDLE -> RUN on the first posedge with `start` low.
- RUN -> DONE at a posedge when `run_en && Halt`, i.e. the HALT instruction retires.
- RUN -> DONE with `timeout` set when the watchdog fires (WDOG≠0 and `cycle_ct` == WDOG-1 at that edge).
- DONE is terminal. Only `start` leaves DONE.
- `run_en` is combinational: (state==RUN) && !stall. It is 0 in IDLE and DONE.
- Counter increments on each posedge in RUN:
  - `cycle_ct` +1 every cycle.
  - `stall_ct` +1 when `stall`.
  - `instr_ct` +1 when `run_en`.
  - `ev_ct[i]` +1 when `run_en && ev[i]`.
- `ev` is ignored on stalled cycles, so each event counts once per retired instruction.
- The retiring HALT cycle is counted in `cycle_ct` and `instr_ct`. Its `ev` bits count as well.
- Saturation: a counter at 2^CW-1 holds its value and sets its `ovf` bit on the edge where it would have wrapped. `ovf` bits are sticky until `start`.
- All counters freeze in DONE.
- Watchdog and HALT in the same cycle: the FSM goes to DONE, `timeout`=1, and the HALT still retires and is counted.
- Halt asserted during stall has no effect until the stall clears.
- `start` asserted mid-run clears everything immediately (asynchronously). After release the FSM restarts from IDLE.

## Timing
- All outputs except `run_en` are registered. Counter values are visible the cycle after the event.
- `run_en` has zero latency from `stall` and from the state register.
- `program_done` rises the cycle after the HALT retires.
- On the edge HALT retires, `run_en`=1. After that edge, `run_en`=0.
- First instruction retires at the earliest in the second cycle after `start` falls. The first cycle is IDLE -> RUN.
- Watchdog expiry with WDOG=N: `program_done` rises after exactly N RUN cycles, and `cycle_ct`==N.

## Test plan
- Basic halt: release `start`, no stalls, Halt on the 10th RUN cycle. Require `program_done` rises the next cycle, `cycle_ct`=`instr_ct`=10, `stall_ct`=0, `timeout`=0.
- Stalls and events: 20 RUN cycles, `stall` high on 5 of them, `ev[0]` held high throughout, Halt on cycle 20. Require `instr_ct`=15, `stall_ct`=5, `ev_ct[0]`=15.
- Halt under stall: Halt held with `stall` high for 3 cycles. Require `run_en`=0 and no DONE until `stall` drops. DONE follows one cycle after that.
- Saturation with CW=4: run 20 cycles, no halt. Require `cycle_ct`=15, `ovf[0]`=1, `ovf[1]`=1. After `start` pulses, all values are 0.
- Watchdog with WDOG=8: Halt never asserted. Require `program_done`=`timeout`=1 after 8 RUN cycles, `cycle_ct`=8. Counters hold afterwards.
- Mid-run reset: assert `start` asynchronously, between clock edges, at cycle 6. Require all outputs 0 before the next edge, then a clean restart from IDLE.
